// File: rtl/iterative_alu_if.sv
// Handshake bundle for iterative_alu: operand request port and result response port.
// The master side is the pipeline stage driving operands; the slave side is the ALU.
interface iterative_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             div_zero;

    modport master (
        output in_valid,
        output op,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  div_zero
    );

    modport slave (
        input  in_valid,
        input  op,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output div_zero
    );
endinterface

// File: rtl/iterative_alu.sv
// Execute-stage ALU: single-cycle logic/arith/compare/shift ops plus iterative
// shift-add multiply and restoring divide/remainder, behind valid/ready handshakes.
module iterative_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    iterative_alu_if.slave bus
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = $clog2(WIDTH + 1);

    localparam logic [3:0] OpAdd   = 4'd0;
    localparam logic [3:0] OpSub   = 4'd1;
    localparam logic [3:0] OpAnd   = 4'd2;
    localparam logic [3:0] OpOr    = 4'd3;
    localparam logic [3:0] OpXor   = 4'd4;
    localparam logic [3:0] OpNot   = 4'd5;
    localparam logic [3:0] OpSlt   = 4'd6;
    localparam logic [3:0] OpSltu  = 4'd7;
    localparam logic [3:0] OpSeq   = 4'd8;
    localparam logic [3:0] OpSll   = 4'd9;
    localparam logic [3:0] OpSrl   = 4'd10;
    localparam logic [3:0] OpSra   = 4'd11;
    localparam logic [3:0] OpMul   = 4'd12;
    localparam logic [3:0] OpDivu  = 4'd13;
    localparam logic [3:0] OpRemu  = 4'd14;
    localparam logic [3:0] OpPassb = 4'd15;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           r_state;
    logic [3:0]       r_op;
    logic [CW-1:0]    r_cnt;
    // MUL: acc = product, mcand = shifted multiplicand, mplier = shifted multiplier.
    // DIV: acc = partial remainder, mcand = divisor, mplier = dividend/quotient shifter.
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_result;
    logic             r_div_zero;
    logic             r_out_valid;

    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu;
    logic             w_is_div;
    logic             w_div_zero;
    logic             w_iterative;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_rem_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_acc_nx;
    logic [WIDTH-1:0] w_iter_result;

    assign w_shamt     = bus.b[SHW-1:0];
    assign w_is_div    = (bus.op == OpDivu) || (bus.op == OpRemu);
    assign w_div_zero  = w_is_div && (bus.b == '0);
    assign w_iterative = (bus.op == OpMul) || (w_is_div && (bus.b != '0));

    always_comb begin
        w_alu = '0;
        case (bus.op)
            OpAdd:   w_alu = bus.a + bus.b;
            OpSub:   w_alu = bus.a - bus.b;
            OpAnd:   w_alu = bus.a & bus.b;
            OpOr:    w_alu = bus.a | bus.b;
            OpXor:   w_alu = bus.a ^ bus.b;
            OpNot:   w_alu = ~bus.a;
            OpSlt:   w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OpSltu:  w_alu = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OpSeq:   w_alu = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
            OpSll:   w_alu = bus.a << w_shamt;
            OpSrl:   w_alu = bus.a >> w_shamt;
            OpSra:   w_alu = $signed(bus.a) >>> w_shamt;
            // Only reached here with b == 0; nonzero divisors take the iterative path.
            OpDivu:  w_alu = '1;
            OpRemu:  w_alu = bus.a;
            OpPassb: w_alu = bus.b;
            default: w_alu = '0;
        endcase
    end

    // One restoring-divide step: shift in the next dividend MSB, subtract if it fits.
    assign w_rem_sh   = {r_acc, r_mplier[WIDTH-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_mcand};
    assign w_ge       = (w_rem_sh >= {1'b0, r_mcand});
    assign w_rem_nx   = w_ge ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx   = {r_mplier[WIDTH-2:0], w_ge};

    assign w_acc_nx   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        w_iter_result = w_rem_nx;
        if (r_op == OpMul) begin
            w_iter_result = w_acc_nx;
        end else if (r_op == OpDivu) begin
            w_iter_result = w_quo_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_op        <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_result    <= '0;
            r_div_zero  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        r_op <= bus.op;
                        if (w_iterative) begin
                            r_acc    <= '0;
                            r_mcand  <= (bus.op == OpMul) ? bus.a : bus.b;
                            r_mplier <= (bus.op == OpMul) ? bus.b : bus.a;
                            r_cnt    <= CW'(WIDTH);
                            r_state  <= StBusy;
                        end else begin
                            r_result    <= w_alu;
                            r_div_zero  <= w_div_zero;
                            r_out_valid <= 1'b1;
                            r_state     <= StDone;
                        end
                    end
                end
                StBusy: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_op == OpMul) begin
                        r_acc    <= w_acc_nx;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                    end else begin
                        r_acc    <= w_rem_nx;
                        r_mplier <= w_quo_nx;
                    end
                    if (r_cnt == CW'(1)) begin
                        r_result    <= w_iter_result;
                        r_div_zero  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.div_zero  = r_div_zero;

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu: reference model feeds a scoreboard queue,
// results are popped and compared when the DUT presents out_valid.
module tb_iterative_alu;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         dz;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_bad;
    exp_t sb[$];

    iterative_alu_if #(.WIDTH(W)) bus ();

    iterative_alu #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t         e;
        logic [4:0]   sh;
        logic [2*W-1:0] prod;
        sh    = b[4:0];
        e.dz  = 1'b0;
        e.res = '0;
        case (op)
            4'd0:  e.res = a + b;
            4'd1:  e.res = a - b;
            4'd2:  e.res = a & b;
            4'd3:  e.res = a | b;
            4'd4:  e.res = a ^ b;
            4'd5:  e.res = ~a;
            4'd6:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  e.res = (a < b) ? 32'd1 : 32'd0;
            4'd8:  e.res = (a == b) ? 32'd1 : 32'd0;
            4'd9:  e.res = a << sh;
            4'd10: e.res = a >> sh;
            4'd11: e.res = $signed(a) >>> sh;
            4'd12: begin
                prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.res = prod[W-1:0];
            end
            4'd13: begin
                e.dz  = (b == '0);
                e.res = (b == '0) ? '1 : a / b;
            end
            4'd14: begin
                e.dz  = (b == '0);
                e.res = (b == '0) ? a : a % b;
            end
            default: e.res = b;
        endcase
        return e;
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [W-1:0] b);
        if (op == 4'd12 || ((op == 4'd13 || op == 4'd14) && b != '0)) return W + 1;
        return 1;
    endfunction

    // Issue one op, wait (bounded) for completion, compare; optionally pulse in_valid
    // while busy and/or hold out_ready low for 'hold' cycles before draining.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit pulse, input int hold);
        int   lat;
        bit   busy_bad;
        bit   hold_bad;
        exp_t e;
        busy_bad = 1'b0;
        hold_bad = 1'b0;
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.out_ready = (hold == 0);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        sb.push_back(model(op, a, b));
        @(posedge clk);
        lat = 1;
        #1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            if (pulse) begin
                if (bus.in_ready !== 1'b0) busy_bad = 1'b1;
                bus.in_valid = 1'b1;
                bus.op       = 4'd0;
                bus.a        = 32'h1111_1111;
                bus.b        = 32'h2222_2222;
            end
            @(posedge clk);
            lat++;
            #1;
        end
        bus.in_valid = 1'b0;
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(op, b)));
        if (pulse) chk({tag, "_busy_in_ready"}, 64'(busy_bad), 64'd0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_result"}, 64'(bus.result), 64'(e.res));
            chk({tag, "_div_zero"}, 64'(bus.div_zero), 64'(e.dz));
            if (hold > 0) begin
                for (int i = 0; i < hold; i++) begin
                    @(posedge clk);
                    #1;
                    if (bus.out_valid !== 1'b1 || bus.result !== e.res ||
                        bus.in_ready !== 1'b0) hold_bad = 1'b1;
                end
                chk({tag, "_hold_stable"}, 64'(hold_bad), 64'd0);
                @(negedge clk);
                bus.out_ready = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "_drain_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_drain_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        logic [3:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           sel;
        n_chk         = 0;
        n_bad         = 0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        do_op("add_wrap", 4'd0,  32'hFFFF_FFFF, 32'd2, 1'b0, 0);
        do_op("slt",      4'd6,  32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        do_op("sltu",     4'd7,  32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        do_op("sra",      4'd11, 32'h8000_0000, 32'h0000_0024, 1'b0, 0);
        do_op("sll",      4'd9,  32'd1, 32'd31, 1'b0, 0);
        do_op("srl",      4'd10, 32'h8000_00F0, 32'hFFFF_FFE4, 1'b0, 0);
        do_op("sub",      4'd1,  32'd3, 32'd5, 1'b0, 0);
        do_op("and",      4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 0);
        do_op("or",       4'd3,  32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 0);
        do_op("xor",      4'd4,  32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 0);
        do_op("not",      4'd5,  32'h1234_5678, 32'd0, 1'b0, 0);
        do_op("seq",      4'd8,  32'hABCD_0001, 32'hABCD_0001, 1'b0, 0);
        do_op("passb",    4'd15, 32'd7, 32'hCAFE_F00D, 1'b0, 0);
        do_op("mul",      4'd12, 32'h0001_0003, 32'h0002_0005, 1'b1, 0);
        do_op("divu",     4'd13, 32'd100, 32'd7, 1'b0, 0);
        do_op("remu",     4'd14, 32'd100, 32'd7, 1'b0, 0);
        do_op("divu_z",   4'd13, 32'd5, 32'd0, 1'b0, 0);
        do_op("remu_z",   4'd14, 32'd5, 32'd0, 1'b0, 0);
        do_op("divu_big", 4'd13, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 0);
        do_op("mul_bp",   4'd12, 32'hDEAD_BEEF, 32'h0000_1001, 1'b0, 10);

        for (int i = 0; i < 24; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            sel = $urandom_range(0, 3);
            rb  = (sel == 0) ? 32'd0 : ((sel == 1) ? 32'($urandom_range(1, 255)) : $urandom);
            do_op("rand", rop, ra, rb, 1'b0, 0);
        end

        // Leave a nonzero result behind so the reset clear is observable.
        do_op("pre_rst", 4'd15, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 4'd13;
        bus.a        = 32'd100;
        bus.b        = 32'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_result", 64'(bus.result), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (W + 4) @(posedge clk);
        #1;
        chk("postrst_no_stale", 64'(bus.out_valid), 64'd0);
        do_op("postrst_add", 4'd0, 32'd3, 32'd4, 1'b0, 0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
